// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, command/response bytes,
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_ACK,
    TX_WAIT_IDLE
  } tx_state_e;

  localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronisers for the PS/2 pins plus a falling-edge strobe per pin.
// Flops reset to 1 (idle bus level) so reset release never fakes an edge.
module ps2_edge_sync #(
  parameter int NUM = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NUM-1:0] pin_i,
  output logic [NUM-1:0] sync_o,
  output logic [NUM-1:0] fall_o
);

  logic [NUM-1:0] s1_q, s2_q, s3_q;

  // metastability chain plus one delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '1;
      s2_q <= '1;
      s3_q <= '1;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = s3_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shifts a byte out
// on device clocks, reads the ACK bit, and guards the whole frame with a timeout.
// Optional feature macro: PS2_TX_ACK_CHECK_EN (a high ACK bit raises ERROR).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  input  logic [7:0] data_i,
  input  logic       write_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

  // bit 0 = clock pin, bit 1 = data pin
  logic [1:0] pin_s, pin_f;

  ps2_edge_sync #(.NUM(2)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pin_i  ({ps2_data_i, ps2_clk_i}),
    .sync_o (pin_s),
    .fall_o (pin_f)
  );

  wire clk_s    = pin_s[0];
  wire data_s   = pin_s[1];
  wire clk_fall = pin_f[0];

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             par_q, par_d;
  logic             ack_bad_q, ack_bad_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // state, shifter, shared inhibit/timeout counter and result pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      par_q     <= 1'b0;
      ack_bad_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      par_q     <= par_d;
      ack_bad_q <= ack_bad_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // next state and pin drive; pin drive decodes from state so reset frees the bus at once
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    bit_d         = bit_q;
    par_d         = par_q;
    ack_bad_d     = ack_bad_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    ps2_clk_oe_o  = 1'b0;
    ps2_data_oe_o = 1'b0;
    case (state_q)
      TX_IDLE: if (write_i) begin
        sh_d      = data_i;
        par_d     = odd_parity(data_i);
        bit_d     = '0;
        cnt_d     = '0;
        ack_bad_d = 1'b0;
        state_d   = TX_INHIBIT;
      end
      TX_INHIBIT: begin
        ps2_clk_oe_o  = 1'b1;
        ps2_data_oe_o = (cnt_q == INH_LAST);
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        ps2_data_oe_o = 1'b1;
        if (clk_fall) state_d = TX_DATA;
      end
      TX_DATA: begin
        ps2_data_oe_o = ~sh_q[0];
        if (clk_fall) begin
          if (bit_q == 3'd7) state_d = TX_PARITY;
          else begin
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        ps2_data_oe_o = ~par_q;
        if (clk_fall) state_d = TX_STOP;
      end
      TX_STOP: if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
        ack_bad_d = data_s;
`else
        ack_bad_d = 1'b0;
`endif
        state_d = TX_ACK;
      end
      TX_ACK: state_d = TX_WAIT_IDLE;
      TX_WAIT_IDLE: if (clk_s && data_s) begin
        done_d  = ~ack_bad_q;
        err_d   = ack_bad_q;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
    // frame watchdog from clock release until the line is idle again
    if (state_q inside {TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_ACK, TX_WAIT_IDLE}) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TO_LAST) begin
        done_d  = 1'b0;
        err_d   = 1'b1;
        state_d = TX_IDLE;
      end
    end
  end

  assign busy_o  = (state_q != TX_IDLE);
  assign done_o  = done_q;
  assign error_o = err_q;

endmodule
